// File: rtl/adc_capture_buf.sv
// adc_capture_buf
// Capture buffer upstream of the GMII UDP packet sender. On a trigger it packs
// a burst of 16-bit ADC samples into 32-bit words in an internal RAM, requests
// a send, holds the buffer stable until the sender returns to idle and then
// re-arms.
//
// Ports:
//   clk          system clock (sender runs on the negedge of the same clock)
//   rst          synchronous active-high reset
//   capture_en   level; 0 returns to DISARMED once any send completes
//   trig         single-cycle capture trigger
//   cfg_length   samples per burst, sampled at trigger
//   adc_data     ADC sample
//   adc_valid    adc_data valid this cycle
//   ram_rd_addr  word read address from the sender
//   tx_state     sender state, used for completion detection
//   datain       registered RAM read data (1 clk latency)
//   Data_Length  latched burst length in samples
//   ipsend_en    send request level to the sender
//   busy         high in CAPTURE, REQ and SENDING
//   overrun_cnt  saturating count of triggers dropped while busy
module adc_capture_buf #(
  parameter int unsigned MAX_WORDS = 8192,
  parameter logic [3:0]  IDLE_CODE = 4'b0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture_en,
  input  logic        trig,
  input  logic [13:0] cfg_length,
  input  logic [15:0] adc_data,
  input  logic        adc_valid,
  input  logic [12:0] ram_rd_addr,
  input  logic [3:0]  tx_state,
  output logic [31:0] datain,
  output logic [13:0] Data_Length,
  output logic        ipsend_en,
  output logic        busy,
  output logic [15:0] overrun_cnt
);

  typedef enum logic [2:0] {
    S_DISARMED,
    S_ARMED,
    S_CAPTURE,
    S_REQ,
    S_SENDING
  } state_t;

  state_t      state_q, state_d;
  logic [13:0] len_q, len_d;
  logic [12:0] wptr_q, wptr_d;
  logic [13:0] cnt_q, cnt_d;
  logic        phase_q, phase_d;
  logic [15:0] hold_q, hold_d;
  logic [15:0] ovr_q, ovr_d;
  logic [31:0] rdata_q;

  logic        we;
  logic [31:0] wdata;
  logic        last;
  logic        busy_w;

  logic [31:0] ram_q [MAX_WORDS];

  assign busy_w = (state_q == S_CAPTURE) || (state_q == S_REQ) ||
                  (state_q == S_SENDING);
  assign last   = (cnt_q == (len_q - 14'd1));

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    hold_d  = hold_q;
    ovr_d   = ovr_q;
    we      = 1'b0;
    wdata   = '0;

    case (state_q)
      S_DISARMED: begin
        if (capture_en) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (trig && (cfg_length != 14'd0)) begin
          state_d = S_CAPTURE;
          len_d   = cfg_length;
          wptr_d  = '0;
          cnt_d   = '0;
          phase_d = 1'b0;
        end else if (!capture_en) begin
          state_d = S_DISARMED;
        end
      end
      S_CAPTURE: begin
        if (adc_valid) begin
          cnt_d = cnt_q + 14'd1;
          if (!phase_q) begin
            if (last) begin
              // odd-length tail: lone sample padded into the low half
              we      = 1'b1;
              wdata   = {16'h0000, adc_data};
              state_d = S_REQ;
            end else begin
              hold_d  = adc_data;
              phase_d = 1'b1;
            end
          end else begin
            we      = 1'b1;
            wdata   = {adc_data, hold_q};
            phase_d = 1'b0;
            // pointer is left on the final word so a full-depth burst never wraps
            if (last) state_d = S_REQ;
            else      wptr_d  = wptr_q + 13'd1;
          end
        end
      end
      S_REQ: begin
        if (tx_state != IDLE_CODE) state_d = S_SENDING;
      end
      S_SENDING: begin
        if (tx_state == IDLE_CODE) state_d = capture_en ? S_ARMED : S_DISARMED;
      end
      default: state_d = S_DISARMED;
    endcase

    if (trig && busy_w && (ovr_q != 16'hFFFF)) ovr_d = ovr_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_DISARMED;
      len_q   <= '0;
      wptr_q  <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      hold_q  <= '0;
      ovr_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      hold_q  <= hold_d;
      ovr_q   <= ovr_d;
      rdata_q <= ram_q[ram_rd_addr];
    end
  end

  // RAM contents survive reset
  always_ff @(posedge clk) begin
    if (we && !rst) ram_q[wptr_q] <= wdata;
  end

  assign datain      = rdata_q;
  assign Data_Length = len_q;
  assign ipsend_en   = (state_q == S_REQ);
  assign busy        = busy_w;
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_adc_capture_buf.sv
module tb_adc_capture_buf;

  logic        clk;
  logic        rst;
  logic        capture_en;
  logic        trig;
  logic [13:0] cfg_length;
  logic [15:0] adc_data;
  logic        adc_valid;
  logic [12:0] ram_rd_addr;
  logic [3:0]  tx_state;
  logic [31:0] datain;
  logic [13:0] Data_Length;
  logic        ipsend_en;
  logic        busy;
  logic [15:0] overrun_cnt;

  int checks = 0;
  int errors = 0;

  adc_capture_buf #(.MAX_WORDS(8192), .IDLE_CODE(4'b0000)) dut (
    .clk(clk), .rst(rst), .capture_en(capture_en), .trig(trig),
    .cfg_length(cfg_length), .adc_data(adc_data), .adc_valid(adc_valid),
    .ram_rd_addr(ram_rd_addr), .tx_state(tx_state), .datain(datain),
    .Data_Length(Data_Length), .ipsend_en(ipsend_en), .busy(busy),
    .overrun_cnt(overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fire_trig(input logic [13:0] len);
    cfg_length = len;
    trig = 1'b1;
    tick();
    trig = 1'b0;
  endtask

  task automatic feed(input logic [15:0] d);
    adc_data  = d;
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic finish_send();
    tx_state = 4'h2;
    tick();
    tick();
    tx_state = 4'h0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (ipsend_en !== 1'b0) begin errors++; $display("FAIL reset_ipsend got %0b want 0", ipsend_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (Data_Length !== 14'd0) begin errors++; $display("FAIL reset_len got %0d want 0", Data_Length); end
    checks++; if (datain !== 32'h0) begin errors++; $display("FAIL reset_datain got %h want 0", datain); end
    checks++; if (overrun_cnt !== 16'h0) begin errors++; $display("FAIL reset_ovr got %h want 0", overrun_cnt); end
    rst = 1'b0;
    capture_en = 1'b1;
    tick();
  endtask

  task automatic test_even_burst();
    fire_trig(14'd4);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL even_busy_rise got %0b want 1", busy); end
    feed(16'h1111);
    feed(16'h2222);
    trig = 1'b1;          // dropped trigger during CAPTURE
    feed(16'h3333);
    trig = 1'b0;
    checks++; if (ipsend_en !== 1'b0) begin errors++; $display("FAIL even_early_req got %0b want 0", ipsend_en); end
    feed(16'h4444);
    checks++; if (ipsend_en !== 1'b1) begin errors++; $display("FAIL even_req got %0b want 1", ipsend_en); end
    checks++; if (Data_Length !== 14'd4) begin errors++; $display("FAIL even_len got %0d want 4", Data_Length); end
    checks++; if (overrun_cnt !== 16'd1) begin errors++; $display("FAIL even_ovr got %0d want 1", overrun_cnt); end
    ram_rd_addr = 13'd0; tick();
    checks++; if (datain !== 32'h22221111) begin errors++; $display("FAIL even_w0 got %h want 22221111", datain); end
    ram_rd_addr = 13'd1; tick();
    checks++; if (datain !== 32'h44443333) begin errors++; $display("FAIL even_w1 got %h want 44443333", datain); end
  endtask

  task automatic test_handshake_overrun();
    repeat (5) tick();
    checks++; if (ipsend_en !== 1'b1) begin errors++; $display("FAIL hs_req_hold got %0b want 1", ipsend_en); end
    tx_state = 4'h3;
    tick();
    checks++; if (ipsend_en !== 1'b0) begin errors++; $display("FAIL hs_req_drop got %0b want 0", ipsend_en); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hs_sending_busy got %0b want 1", busy); end
    adc_data = 16'hDEAD;
    adc_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      trig = (i == 10) || (i == 100) || (i == 200);
      tick();
    end
    trig = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hs_hold_busy got %0b want 1", busy); end
    tx_state = 4'h0;
    tick();
    adc_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hs_rearm_busy got %0b want 0", busy); end
    checks++; if (overrun_cnt !== 16'd4) begin errors++; $display("FAIL ovr_count got %0d want 4", overrun_cnt); end
    ram_rd_addr = 13'd0; tick();
    checks++; if (datain !== 32'h22221111) begin errors++; $display("FAIL ovr_w0_kept got %h want 22221111", datain); end
    ram_rd_addr = 13'd1; tick();
    checks++; if (datain !== 32'h44443333) begin errors++; $display("FAIL ovr_w1_kept got %h want 44443333", datain); end
  endtask

  task automatic test_six_burst();
    fire_trig(14'd6);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL six_retrig_busy got %0b want 1", busy); end
    for (int i = 1; i <= 6; i++) feed({2{8'(i)}});
    checks++; if (ipsend_en !== 1'b1) begin errors++; $display("FAIL six_req got %0b want 1", ipsend_en); end
    ram_rd_addr = 13'd2; tick();
    checks++; if (datain !== 32'h06060505) begin errors++; $display("FAIL six_w2 got %h want 06060505", datain); end
    finish_send();
  endtask

  task automatic test_odd_burst();
    fire_trig(14'd3);
    feed(16'hAAAA);
    feed(16'hBBBB);
    feed(16'hCCCC);
    checks++; if (ipsend_en !== 1'b1) begin errors++; $display("FAIL odd_req got %0b want 1", ipsend_en); end
    checks++; if (Data_Length !== 14'd3) begin errors++; $display("FAIL odd_len got %0d want 3", Data_Length); end
    ram_rd_addr = 13'd0; tick();
    checks++; if (datain !== 32'hBBBBAAAA) begin errors++; $display("FAIL odd_w0 got %h want bbbbaaaa", datain); end
    ram_rd_addr = 13'd1; tick();
    checks++; if (datain !== 32'h0000CCCC) begin errors++; $display("FAIL odd_w1 got %h want 0000cccc", datain); end
    ram_rd_addr = 13'd2; tick();
    checks++; if (datain !== 32'h06060505) begin errors++; $display("FAIL odd_w2_untouched got %h want 06060505", datain); end
    finish_send();
  endtask

  task automatic test_zero_length();
    fire_trig(14'd0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy got %0b want 0", busy); end
    feed(16'h5555);
    feed(16'h6666);
    checks++; if (ipsend_en !== 1'b0) begin errors++; $display("FAIL zero_req got %0b want 0", ipsend_en); end
    checks++; if (Data_Length !== 14'd3) begin errors++; $display("FAIL zero_len_kept got %0d want 3", Data_Length); end
    ram_rd_addr = 13'd0; tick();
    checks++; if (datain !== 32'hBBBBAAAA) begin errors++; $display("FAIL zero_w0_kept got %h want bbbbaaaa", datain); end
  endtask

  task automatic test_reset_mid_capture();
    fire_trig(14'd20);
    for (int i = 0; i < 10; i++) feed(16'h7000 + 16'(i));
    rst = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %0b want 0", busy); end
    checks++; if (ipsend_en !== 1'b0) begin errors++; $display("FAIL mid_rst_req got %0b want 0", ipsend_en); end
    checks++; if (Data_Length !== 14'd0) begin errors++; $display("FAIL mid_rst_len got %0d want 0", Data_Length); end
    checks++; if (datain !== 32'h0) begin errors++; $display("FAIL mid_rst_datain got %h want 0", datain); end
    checks++; if (overrun_cnt !== 16'h0) begin errors++; $display("FAIL mid_rst_ovr got %h want 0", overrun_cnt); end
    rst = 1'b0;
    tick();               // DISARMED -> ARMED
    fire_trig(14'd2);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_rst_rearm got %0b want 1", busy); end
    rst = 1'b1; tick();
    rst = 1'b0; tick();
  endtask

  task automatic test_max_length();
    fire_trig(14'd16383);
    for (int i = 0; i < 16383; i++) feed(16'(i));
    checks++; if (ipsend_en !== 1'b1) begin errors++; $display("FAIL max_req got %0b want 1", ipsend_en); end
    checks++; if (dut.wptr_q !== 13'd8191) begin errors++; $display("FAIL max_wptr got %0d want 8191", dut.wptr_q); end
    ram_rd_addr = 13'd0; tick();
    checks++; if (datain !== 32'h00010000) begin errors++; $display("FAIL max_w0 got %h want 00010000", datain); end
    ram_rd_addr = 13'd8190; tick();
    checks++; if (datain !== 32'h3FFD3FFC) begin errors++; $display("FAIL max_w8190 got %h want 3ffd3ffc", datain); end
    ram_rd_addr = 13'd8191; tick();
    checks++; if (datain !== 32'h00003FFE) begin errors++; $display("FAIL max_w8191 got %h want 00003ffe", datain); end
  endtask

  task automatic test_saturation();
    tx_state = 4'h1;
    tick();               // REQ -> SENDING
    trig = 1'b1;
    repeat (65534) tick();
    checks++; if (overrun_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got %h want fffe", overrun_cnt); end
    tick();
    checks++; if (overrun_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got %h want ffff", overrun_cnt); end
    repeat (5) tick();
    checks++; if (overrun_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h want ffff", overrun_cnt); end
    trig = 1'b0;
    capture_en = 1'b0;
    tx_state = 4'h0;
    tick();               // SENDING -> DISARMED
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dis_busy got %0b want 0", busy); end
    fire_trig(14'd4);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dis_trig_ignored got %0b want 0", busy); end
  endtask

  initial begin
    rst = 1'b1;
    capture_en = 1'b0;
    trig = 1'b0;
    cfg_length = '0;
    adc_data = '0;
    adc_valid = 1'b0;
    ram_rd_addr = '0;
    tx_state = 4'h0;
    test_reset();
    test_even_burst();
    test_handshake_overrun();
    test_six_burst();
    test_odd_burst();
    test_zero_length();
    test_reset_mid_capture();
    test_max_length();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
